// File: rtl/affinex_point_fifo_if.sv
// Point-buffer bus: CPU coordinate write strobes in, show-ahead point stream out.
// The FIFO takes the slave side; the master side is the CPU/engine environment.
interface affinex_point_fifo_if #(
    parameter int WIDTH = 16
);
    logic             wr_x_valid;
    logic [WIDTH-1:0] wr_x_data;
    logic             wr_y_valid;
    logic [WIDTH-1:0] wr_y_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_x;
    logic [WIDTH-1:0] out_y;

    modport master (
        output wr_x_valid, wr_x_data, wr_y_valid, wr_y_data, out_ready,
        input  out_valid, out_x, out_y
    );

    modport slave (
        input  wr_x_valid, wr_x_data, wr_y_valid, wr_y_data, out_ready,
        output out_valid, out_x, out_y
    );
endinterface

// File: rtl/affinex_point_fifo.sv
// Pairs CPU-written X/Y halves into points and queues them for the affine engine.
// Sticky error flags report dropped points and Y writes that have no matching X.
module affinex_point_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    affinex_point_fifo_if.slave bus,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                empty,
    output logic                x_pending,
    output logic                overflow,
    output logic                pair_err
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] x_hold_r;
    logic             x_pending_r;
    logic             overflow_r;
    logic             pair_err_r;
    logic [WIDTH-1:0] mem_x_r [DEPTH];
    logic [WIDTH-1:0] mem_y_r [DEPTH];

    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             push_req_s;
    logic             push_ok_s;
    logic             drop_s;
    logic             orphan_s;
    logic [WIDTH-1:0] push_x_s;

    // Pointers wrap naturally because DEPTH is a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return p + PW'(1);
    endfunction

    // Handshake decode and push/pop arbitration.
    always_comb begin
        full_s     = (count_r == CW'(DEPTH));
        empty_s    = (count_r == CW'(0));
        pop_s      = !empty_s && bus.out_ready;
        push_req_s = bus.wr_y_valid && (bus.wr_x_valid || x_pending_r);
        push_ok_s  = push_req_s && (!full_s || pop_s);
        drop_s     = push_req_s && full_s && !pop_s;
        orphan_s   = bus.wr_y_valid && !bus.wr_x_valid && !x_pending_r;
        if (bus.wr_x_valid) begin
            push_x_s = bus.wr_x_data;
        end else begin
            push_x_s = x_hold_r;
        end
    end

    // Control state: pointers, occupancy, pairing register and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r    <= {PW{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            x_hold_r    <= {WIDTH{1'b0}};
            x_pending_r <= 1'b0;
            overflow_r  <= 1'b0;
            pair_err_r  <= 1'b0;
        end else if (clear) begin
            rd_ptr_r    <= {PW{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            x_pending_r <= 1'b0;
            overflow_r  <= 1'b0;
            pair_err_r  <= 1'b0;
        end else begin
            if (bus.wr_x_valid && !bus.wr_y_valid) begin
                x_hold_r    <= bus.wr_x_data;
                x_pending_r <= 1'b1;
            end else if (bus.wr_y_valid) begin
                x_pending_r <= 1'b0;
            end
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (orphan_s) begin
                pair_err_r <= 1'b1;
            end
        end
    end

    // Point storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (!clear && push_ok_s) begin
            mem_x_r[wr_ptr_r] <= push_x_s;
            mem_y_r[wr_ptr_r] <= bus.wr_y_data;
        end
    end

    // Show-ahead head entry, forced to zero while empty.
    always_comb begin
        if (empty_s) begin
            bus.out_x = {WIDTH{1'b0}};
            bus.out_y = {WIDTH{1'b0}};
        end else begin
            bus.out_x = mem_x_r[rd_ptr_r];
            bus.out_y = mem_y_r[rd_ptr_r];
        end
    end

    assign bus.out_valid = !empty_s;
    assign count         = count_r;
    assign full          = full_s;
    assign empty         = empty_s;
    assign x_pending     = x_pending_r;
    assign overflow      = overflow_r;
    assign pair_err      = pair_err_r;
endmodule

// File: tb/tb_affinex_point_fifo.sv
// Directed bench for affinex_point_fifo (DEPTH=4, WIDTH=16) with hand-computed expectations.
module tb_affinex_point_fifo;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          clear;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          x_pending;
    logic          overflow;
    logic          pair_err;
    int            n_checks;
    int            n_errors;

    affinex_point_fifo_if #(.WIDTH(WIDTH)) bus ();

    affinex_point_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .bus       (bus),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .x_pending (x_pending),
        .overflow  (overflow),
        .pair_err  (pair_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, leaving time 1 unit after it for sampling and driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_x_valid = 1'b0;
        bus.wr_y_valid = 1'b0;
        bus.out_ready  = 1'b0;
        clear          = 1'b0;
    endtask

    task automatic write_x(input logic [15:0] x);
        bus.wr_x_valid = 1'b1;
        bus.wr_x_data  = x;
        tick();
        bus.wr_x_valid = 1'b0;
    endtask

    task automatic write_y(input logic [15:0] y);
        bus.wr_y_valid = 1'b1;
        bus.wr_y_data  = y;
        tick();
        bus.wr_y_valid = 1'b0;
    endtask

    task automatic push_pair(input logic [15:0] x, input logic [15:0] y);
        write_x(x);
        write_y(y);
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        bus.wr_x_data  = 16'h0000;
        bus.wr_y_data  = 16'h0000;
        idle_inputs();
        rst = 1'b1;
        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_x", {16'd0, bus.out_x}, 32'd0);
        chk("rst_out_y", {16'd0, bus.out_y}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_x_pending", {31'd0, x_pending}, 32'd0);
        chk("rst_flags", {30'd0, overflow, pair_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Single pair, then pop back to empty.
        write_x(16'h0100);
        chk("single_x_pending", {31'd0, x_pending}, 32'd1);
        chk("single_not_yet_valid", {31'd0, bus.out_valid}, 32'd0);
        write_y(16'hFF00);
        chk("single_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("single_out_x", {16'd0, bus.out_x}, 32'h0100);
        chk("single_out_y", {16'd0, bus.out_y}, 32'hFF00);
        chk("single_count", {29'd0, count}, 32'd1);
        pop_one();
        chk("single_empty", {31'd0, empty}, 32'd1);
        chk("single_out_x_zero", {16'd0, bus.out_x}, 32'd0);

        // Fill to full, overflow, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            push_pair(16'(2 * i + 1), 16'(2 * i + 2));
        end
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_count", {29'd0, count}, 32'd4);
        chk("fill_no_ovf", {31'd0, overflow}, 32'd0);
        push_pair(16'd9, 16'd10);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {29'd0, count}, 32'd4);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_x", {16'd0, bus.out_x}, 32'(2 * i + 1));
            chk("drain_y", {16'd0, bus.out_y}, 32'(2 * i + 2));
            pop_one();
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        do_clear();
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Push into a full buffer while popping.
        for (int i = 0; i < DEPTH; i++) begin
            push_pair(16'(2 * i + 1), 16'(2 * i + 2));
        end
        write_x(16'd9);
        bus.wr_y_valid = 1'b1;
        bus.wr_y_data  = 16'd10;
        bus.out_ready  = 1'b1;
        tick();
        idle_inputs();
        chk("fullpop_count", {29'd0, count}, 32'd4);
        chk("fullpop_no_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            chk("fullpop_drain_x", {16'd0, bus.out_x}, 32'(2 * i + 1));
            chk("fullpop_drain_y", {16'd0, bus.out_y}, 32'(2 * i + 2));
            pop_one();
        end
        chk("fullpop_empty", {31'd0, empty}, 32'd1);

        // Pointer wrap: 3*DEPTH cycles of simultaneous direct push and pop.
        bus.wr_x_valid = 1'b1;
        bus.wr_y_valid = 1'b1;
        bus.wr_x_data  = 16'd100;
        bus.wr_y_data  = 16'd200;
        tick();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            chk("wrap_head_x", {16'd0, bus.out_x}, 32'(100 + i));
            chk("wrap_head_y", {16'd0, bus.out_y}, 32'(200 + i));
            bus.wr_x_data = 16'(101 + i);
            bus.wr_y_data = 16'(201 + i);
            bus.out_ready = 1'b1;
            tick();
            chk("wrap_count", {29'd0, count}, 32'd1);
        end
        idle_inputs();
        pop_one();
        chk("wrap_empty", {31'd0, empty}, 32'd1);

        // Pairing rules.
        write_y(16'd5);
        chk("orphan_pair_err", {31'd0, pair_err}, 32'd1);
        chk("orphan_count", {29'd0, count}, 32'd0);
        write_x(16'd7);
        write_x(16'd8);
        chk("rewrite_no_err_ovf", {31'd0, overflow}, 32'd0);
        write_y(16'd9);
        chk("rewrite_head_x", {16'd0, bus.out_x}, 32'd8);
        chk("rewrite_head_y", {16'd0, bus.out_y}, 32'd9);
        chk("rewrite_count", {29'd0, count}, 32'd1);
        bus.wr_x_valid = 1'b1;
        bus.wr_y_valid = 1'b1;
        bus.wr_x_data  = 16'd11;
        bus.wr_y_data  = 16'd12;
        tick();
        idle_inputs();
        chk("direct_count", {29'd0, count}, 32'd2);
        chk("direct_x_pending", {31'd0, x_pending}, 32'd0);
        pop_one();
        chk("direct_head_x", {16'd0, bus.out_x}, 32'd11);
        chk("direct_head_y", {16'd0, bus.out_y}, 32'd12);
        chk("pair_err_sticky", {31'd0, pair_err}, 32'd1);
        do_clear();

        // Clear wins over simultaneous push and pop.
        for (int i = 0; i < 3; i++) begin
            push_pair(16'(20 + i), 16'(30 + i));
        end
        write_x(16'd40);
        chk("clrpri_pre_count", {29'd0, count}, 32'd3);
        chk("clrpri_pre_pending", {31'd0, x_pending}, 32'd1);
        clear          = 1'b1;
        bus.wr_x_valid = 1'b1;
        bus.wr_y_valid = 1'b1;
        bus.out_ready  = 1'b1;
        tick();
        idle_inputs();
        chk("clrpri_count", {29'd0, count}, 32'd0);
        chk("clrpri_empty", {31'd0, empty}, 32'd1);
        chk("clrpri_pending", {31'd0, x_pending}, 32'd0);
        chk("clrpri_flags", {30'd0, overflow, pair_err}, 32'd0);

        // Asynchronous reset between edges.
        push_pair(16'd50, 16'd60);
        push_pair(16'd51, 16'd61);
        chk("arst_pre_count", {29'd0, count}, 32'd2);
        write_x(16'd52);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", {29'd0, count}, 32'd0);
        chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_empty", {31'd0, empty}, 32'd1);
        chk("arst_out_x", {16'd0, bus.out_x}, 32'd0);
        chk("arst_out_y", {16'd0, bus.out_y}, 32'd0);
        chk("arst_pending", {31'd0, x_pending}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_after_empty", {31'd0, empty}, 32'd1);
        chk("arst_after_full", {31'd0, full}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
